// File: rtl/error_locator_8ch.sv
// Checksum fault locator for an 8-channel complex block: forms the per-lane syndromes,
// then searches one candidate channel per cycle for the single faulty channel.
module error_locator_8ch #(
    parameter int NCH = 8,
    parameter int NS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [NS-1:0][31:0]   cn0,
    input  logic [NS-1:0][31:0]   cn1,
    input  logic [NS-1:0][31:0]   cn2,
    input  logic [NS-1:0][31:0]   cn3,
    input  logic [NS-1:0][31:0]   cn4,
    input  logic [NS-1:0][31:0]   cn5,
    input  logic [NS-1:0][31:0]   cn6,
    input  logic [NS-1:0][31:0]   cn7,
    input  logic [NS-1:0][47:0]   chk_s,
    input  logic [NS-1:0][47:0]   chk_w,
    output logic                  busy,
    output logic                  done_o,
    output logic                  fix_en_o,
    output logic [3:0]            error_code,
    output logic [NS-1:0][16:0]   delta1_real,
    output logic [NS-1:0][16:0]   delta1_imag,
    output logic                  no_error,
    output logic                  uncorrectable
);

    localparam int NL = 2 * NS;

    typedef enum logic [1:0] {S_IDLE, S_SUM, S_SEARCH, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [NCH-1:0][NS-1:0][31:0]  cn_q, cn_d;
    logic [NS-1:0][47:0]           chk_s_q, chk_s_d;
    logic [NS-1:0][47:0]           chk_w_q, chk_w_d;
    logic [NL-1:0][24:0]           d1_q, d1_d;
    logic [NL-1:0][24:0]           d2_q, d2_d;
    logic [NL-1:0][24:0]           acc_q, acc_d;
    logic [2:0]                    k_q, k_d;
    logic                          done_q, done_d;
    logic                          fix_en_q, fix_en_d;
    logic [3:0]                    error_code_q, error_code_d;
    logic [NS-1:0][16:0]           dre_q, dre_d;
    logic [NS-1:0][16:0]           dim_q, dim_d;
    logic                          no_error_q, no_error_d;
    logic                          uncorr_q, uncorr_d;

    logic [NL-1:0][24:0]           d1_c, d2_c;
    logic [NL-1:0]                 ovf_c, match_c;

    // Lane gi: samples 0..NS-1 are the real halves, NS..2NS-1 the imaginary halves.
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        localparam int SMP  = gi % NS;
        localparam int HALF = gi / NS;
        logic [24:0] sum_s, sum_w, chk_s_x, chk_w_x;

        always_comb begin
            sum_s = '0;
            sum_w = '0;
            for (int k = 0; k < NCH; k++) begin
                sum_s = sum_s + 25'(signed'(cn_q[k][SMP][16*HALF +: 16]));
                sum_w = sum_w + 25'(signed'(cn_q[k][SMP][16*HALF +: 16])) * 25'(k + 1);
            end
        end

        assign chk_s_x     = 25'(signed'(chk_s_q[SMP][24*HALF +: 24]));
        assign chk_w_x     = 25'(signed'(chk_w_q[SMP][24*HALF +: 24]));
        assign d1_c[gi]    = sum_s - chk_s_x;
        assign d2_c[gi]    = sum_w - chk_w_x;
        // Fits in 17 signed bits only when bits 24..16 are all equal.
        assign ovf_c[gi]   = !((&d1_c[gi][24:16]) || !(|d1_c[gi][24:16]));
        assign match_c[gi] = (acc_q[gi] == d2_q[gi]);
    end

    always_comb begin
        state_d      = state_q;
        cn_d         = cn_q;
        chk_s_d      = chk_s_q;
        chk_w_d      = chk_w_q;
        d1_d         = d1_q;
        d2_d         = d2_q;
        acc_d        = acc_q;
        k_d          = k_q;
        done_d       = 1'b0;
        fix_en_d     = 1'b0;
        error_code_d = error_code_q;
        dre_d        = dre_q;
        dim_d        = dim_q;
        no_error_d   = no_error_q;
        uncorr_d     = uncorr_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cn_d[0] = cn0;
                    cn_d[1] = cn1;
                    cn_d[2] = cn2;
                    cn_d[3] = cn3;
                    cn_d[4] = cn4;
                    cn_d[5] = cn5;
                    cn_d[6] = cn6;
                    cn_d[7] = cn7;
                    chk_s_d = chk_s;
                    chk_w_d = chk_w;
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                d1_d  = d1_c;
                d2_d  = d2_c;
                acc_d = d1_c;
                k_d   = 3'd0;
                if (d1_c == '0 && d2_c == '0) begin
                    no_error_d   = 1'b1;
                    uncorr_d     = 1'b0;
                    error_code_d = 4'd15;
                    dre_d        = '0;
                    dim_d        = '0;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end else if (|ovf_c) begin
                    no_error_d   = 1'b0;
                    uncorr_d     = 1'b1;
                    error_code_d = 4'd15;
                    dre_d        = '0;
                    dim_d        = '0;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                // acc holds (k+1)*d1; a single fault in channel k makes d2 equal to it.
                if (&match_c) begin
                    no_error_d   = 1'b0;
                    uncorr_d     = 1'b0;
                    error_code_d = {1'b0, k_q};
                    for (int s = 0; s < NS; s++) begin
                        dre_d[s] = d1_q[s][16:0];
                        dim_d[s] = d1_q[s+NS][16:0];
                    end
                    done_d   = 1'b1;
                    fix_en_d = 1'b1;
                    state_d  = S_DONE;
                end else if (k_q != 3'd7) begin
                    k_d = k_q + 3'd1;
                    for (int l = 0; l < NL; l++) begin
                        acc_d[l] = acc_q[l] + d1_q[l];
                    end
                end else begin
                    no_error_d   = 1'b0;
                    uncorr_d     = 1'b1;
                    error_code_d = 4'd15;
                    dre_d        = '0;
                    dim_d        = '0;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cn_q         <= '0;
            chk_s_q      <= '0;
            chk_w_q      <= '0;
            d1_q         <= '0;
            d2_q         <= '0;
            acc_q        <= '0;
            k_q          <= '0;
            done_q       <= 1'b0;
            fix_en_q     <= 1'b0;
            error_code_q <= 4'd15;
            dre_q        <= '0;
            dim_q        <= '0;
            no_error_q   <= 1'b0;
            uncorr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cn_q         <= cn_d;
            chk_s_q      <= chk_s_d;
            chk_w_q      <= chk_w_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            acc_q        <= acc_d;
            k_q          <= k_d;
            done_q       <= done_d;
            fix_en_q     <= fix_en_d;
            error_code_q <= error_code_d;
            dre_q        <= dre_d;
            dim_q        <= dim_d;
            no_error_q   <= no_error_d;
            uncorr_q     <= uncorr_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign fix_en_o      = fix_en_q;
    assign error_code    = error_code_q;
    assign delta1_real   = dre_q;
    assign delta1_imag   = dim_q;
    assign no_error      = no_error_q;
    assign uncorrectable = uncorr_q;

endmodule

// File: tb/tb_error_locator_8ch.sv
// Directed and randomized checks of error_locator_8ch against an integer-arithmetic
// model of the checksum syndromes and single-fault search.
module tb_error_locator_8ch;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [7:0][31:0] cn0, cn1, cn2, cn3, cn4, cn5, cn6, cn7;
    logic [7:0][47:0] chk_s, chk_w;
    logic busy, done_o, fix_en_o, no_error, uncorrectable;
    logic [3:0] error_code;
    logic [7:0][16:0] delta1_real, delta1_imag;

    always #5 clk = ~clk;

    error_locator_8ch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .cn0(cn0), .cn1(cn1), .cn2(cn2), .cn3(cn3),
        .cn4(cn4), .cn5(cn5), .cn6(cn6), .cn7(cn7),
        .chk_s(chk_s), .chk_w(chk_w),
        .busy(busy), .done_o(done_o), .fix_en_o(fix_en_o),
        .error_code(error_code), .delta1_real(delta1_real), .delta1_imag(delta1_imag),
        .no_error(no_error), .uncorrectable(uncorrectable)
    );

    int total = 0;
    int bad = 0;

    // Block contents as plain integers: [channel][sample]
    int cre[8][8];
    int cim[8][8];
    int sre[8], sim[8], wre[8], wim[8];

    // Model predictions
    int exp_lat, exp_ec, exp_fix, exp_noerr, exp_unc, exp_ovf;
    int exp_dre[8], exp_dim[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(32200)) - 16100;
    endfunction

    task automatic gen_clean();
        for (int c = 0; c < 8; c++)
            for (int s = 0; s < 8; s++) begin
                cre[c][s] = rnd16();
                cim[c][s] = rnd16();
            end
        for (int s = 0; s < 8; s++) begin
            sre[s] = 0; sim[s] = 0; wre[s] = 0; wim[s] = 0;
            for (int c = 0; c < 8; c++) begin
                sre[s] += cre[c][s];
                sim[s] += cim[c][s];
                wre[s] += (c + 1) * cre[c][s];
                wim[s] += (c + 1) * cim[c][s];
            end
        end
    endtask

    function automatic logic [7:0][31:0] pack_ch(input int c);
        logic [7:0][31:0] r;
        for (int s = 0; s < 8; s++) r[s] = {16'(cim[c][s]), 16'(cre[c][s])};
        return r;
    endfunction

    task automatic apply();
        cn0 = pack_ch(0); cn1 = pack_ch(1); cn2 = pack_ch(2); cn3 = pack_ch(3);
        cn4 = pack_ch(4); cn5 = pack_ch(5); cn6 = pack_ch(6); cn7 = pack_ch(7);
        for (int s = 0; s < 8; s++) begin
            chk_s[s] = {24'(sim[s]), 24'(sre[s])};
            chk_w[s] = {24'(wim[s]), 24'(wre[s])};
        end
    endtask

    // Reference: syndromes per lane, then first k with d2 == (k+1)*d1 everywhere.
    task automatic predict();
        int d1[16];
        int d2[16];
        bit allz, ovf, hit;
        int found;
        allz = 1; ovf = 0; found = -1;
        for (int l = 0; l < 16; l++) begin
            int s;
            s = l % 8;
            d1[l] = (l < 8) ? -sre[s] : -sim[s];
            d2[l] = (l < 8) ? -wre[s] : -wim[s];
            for (int c = 0; c < 8; c++) begin
                d1[l] += (l < 8) ? cre[c][s] : cim[c][s];
                d2[l] += (c + 1) * ((l < 8) ? cre[c][s] : cim[c][s]);
            end
            if (d1[l] != 0 || d2[l] != 0) allz = 0;
            if (d1[l] < -65536 || d1[l] > 65535) ovf = 1;
        end
        for (int k = 0; k < 8 && found < 0; k++) begin
            hit = 1;
            for (int l = 0; l < 16; l++) if (d2[l] != (k + 1) * d1[l]) hit = 0;
            if (hit) found = k;
        end
        exp_ovf = 0; exp_fix = 0; exp_noerr = 0; exp_unc = 0; exp_ec = 15;
        for (int s = 0; s < 8; s++) begin exp_dre[s] = 0; exp_dim[s] = 0; end
        if (allz) begin
            exp_lat = 1; exp_noerr = 1;
        end else if (ovf) begin
            exp_lat = 1; exp_unc = 1; exp_ovf = 1;
        end else if (found >= 0) begin
            exp_lat = 2 + found; exp_ec = found; exp_fix = 1;
            for (int s = 0; s < 8; s++) begin exp_dre[s] = d1[s]; exp_dim[s] = d1[s+8]; end
        end else begin
            exp_lat = 9; exp_unc = 1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done_o), 32'd0);
        check({tag, ".fix"}, 32'(fix_en_o), 32'd0);
        check({tag, ".ec"}, 32'(error_code), 32'd15);
        check({tag, ".noerr"}, 32'(no_error), 32'd0);
        check({tag, ".unc"}, 32'(uncorrectable), 32'd0);
        check({tag, ".dre"}, 32'(|delta1_real), 32'd0);
        check({tag, ".dim"}, 32'(|delta1_imag), 32'd0);
    endtask

    task automatic run_block(input string tag, input bit poke_busy);
        int n;
        bit got;
        logic [16:0] ev;
        predict();
        apply();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        n = 0; got = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (poke_busy) begin
                in_valid = 1'b1;
                cn0 = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(posedge clk); #1;
            if (done_o) begin got = 1; n = i; end
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".fix"}, 32'(fix_en_o), 32'(exp_fix));
        check({tag, ".ec"}, 32'(error_code), 32'(exp_ec));
        check({tag, ".noerr"}, 32'(no_error), 32'(exp_noerr));
        check({tag, ".unc"}, 32'(uncorrectable), 32'(exp_unc));
        if (!exp_ovf) begin
            for (int s = 0; s < 8; s++) begin
                ev = 17'(exp_dre[s]);
                check($sformatf("%s.dre%0d", tag, s), {15'd0, delta1_real[s]}, {15'd0, ev});
                ev = 17'(exp_dim[s]);
                check($sformatf("%s.dim%0d", tag, s), {15'd0, delta1_imag[s]}, {15'd0, ev});
            end
        end
        @(posedge clk); #1;
        check({tag, ".pulse"}, 32'(done_o), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
        $display("block %s: latency=%0d ec=%0d fix=%0d noerr=%0d unc=%0d",
                 tag, n, error_code, fix_en_o, no_error, uncorrectable);
    endtask

    initial begin
        int dn;
        rst = 1'b1;
        in_valid = 1'b0;
        gen_clean();
        apply();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            gen_clean();
            run_block($sformatf("clean%0d", i), 1'b0);
        end

        gen_clean(); cre[3][5] += 100;
        run_block("cn3_re5_p100", 1'b0);

        gen_clean();
        for (int s = 0; s < 8; s++) cim[7][s] -= 1;
        run_block("cn7_im_m1", 1'b0);

        gen_clean(); cre[0][2] += 1; cre[2][2] += 1;
        run_block("alias_0_2", 1'b0);

        gen_clean(); cim[0][6] += 1; cim[1][6] += 2;
        run_block("two_fault", 1'b0);

        gen_clean(); sre[4] += 70000;
        run_block("chk_s_ovf", 1'b1);

        gen_clean(); wim[1] += 9;
        run_block("chk_w_only", 1'b0);

        gen_clean(); sre[0] -= 5;
        run_block("chk_s_only", 1'b0);

        for (int i = 0; i < 6; i++) begin
            int c, l, v;
            gen_clean();
            c = int'($urandom_range(7));
            l = int'($urandom_range(15));
            v = int'($urandom_range(1000, 1));
            if ($urandom_range(1) == 1) v = -v;
            if (l < 8) cre[c][l] += v; else cim[c][l-8] += v;
            run_block($sformatf("rand%0d_ch%0d", i, c), 1'b0);
        end

        // Abort a block while searching candidate k=4 (fault sits in channel 6).
        gen_clean(); cre[6][2] += 50;
        apply();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_o) dn++;
        end
        check("abort.no_done", 32'(dn), 32'd0);
        $display("block abort: done pulses after reset=%0d", dn);

        gen_clean(); cim[5][0] += 33;
        run_block("after_abort", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/error_locator_8ch.md
Name: error_locator_8ch

Overview:
- Checksum-based fault detector, directly upstream of the error-fixer stage.
- Takes one 8-sample complex block from 8 data channels, plus a plain-sum checksum channel and a weighted-sum checksum channel.
- Computes the per-sample syndrome delta1, locates the single faulty channel with a sequential search, and reports the result.
- Its outputs drive the fixer's error_code, delta1_real, delta1_imag and en_i inputs.

Parameters:
- NCH, 8, number of data channels (fixed; search counter and error_code sized for 8).
- NS, 8, complex samples per channel block.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  block present on the cn*/chk* inputs; accepted only in IDLE.
- cn0..cn7  in  [7:0][31:0] each  data channels; per sample, [15:0] signed real, [31:16] signed imag.
- chk_s  in  [7:0][47:0]  sum checksum; per sample, [23:0] signed real, [47:24] signed imag.
- chk_w  in  [7:0][47:0]  weighted checksum, sum of (k+1)*cnk; same packing as chk_s.
- busy  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle pulse: result outputs valid.
- fix_en_o  out  1  one-cycle pulse coincident with done_o, only when a correctable error was located; connects to fixer en_i.
- error_code  out  4  located channel 0..7; 4'd15 when none or uncorrectable.
- delta1_real  out  signed [16:0] x8  per-sample real syndrome.
- delta1_imag  out  signed [16:0] x8  per-sample imag syndrome.
- no_error  out  1  last block clean.
- uncorrectable  out  1  last block faulty but not locatable.

Behaviour:
- Reset: state IDLE; all outputs 0, except error_code = 4'd15; all internal registers cleared.
- Reset asserted mid-operation aborts the block; no done_o is produced for it.
- States: IDLE, SUM, SEARCH, DONE.
- IDLE:
  - in_valid=1 registers all inputs and moves to SUM.
  - in_valid outside IDLE is ignored; no queueing.
- SUM: one cycle. Sign-extend everything and compute 16 lanes (8 samples x real/imag):
  - d1 = (sum of cnk lane) - chk_s lane, 25-bit.
  - d2 = (sum of (k+1)*cnk lane) - chk_w lane, 25-bit.
  - Register d1, d2; set accumulator acc = d1; set k = 0.
  - Transition priority:
    - All d1 and all d2 zero: no_error=1, uncorrectable=0, error_code=15, deltas=0, go DONE.
    - Else any d1 lane outside signed 17-bit range: uncorrectable=1, error_code=15, go DONE.
    - Else go SEARCH.
- SEARCH: one candidate k per cycle.
  - Match if acc == d2 in all 16 lanes; acc holds (k+1)*d1.
  - Match: error_code=k, delta1_* = d1 truncated to 17 bits, no_error=0, uncorrectable=0, go DONE.
  - No match and k<7: k <= k+1, acc <= acc+d1.
  - No match and k==7: uncorrectable=1, error_code=15, delta1_*=0, go DONE.
- DONE: done_o=1 for exactly one cycle; fix_en_o=1 only on a SEARCH match; return to IDLE.
- Result registers (error_code, delta1_*, no_error, uncorrectable) update only on the transition into DONE and hold until the next one.
- Latency, with in_valid sampled at edge 0:
  - Clean or overflow block: done_o in cycle 2.
  - Fault in channel k: done_o in cycle 3+k.
  - Uncorrectable after full search: done_o in cycle 10.
  - A new in_valid is accepted in the cycle after DONE.
- d1 all zero with d2 nonzero (fault only in chk_w): every candidate fails → uncorrectable.
- d1 nonzero with d2 zero (fault only in chk_s): every candidate fails → uncorrectable.
- Arithmetic is two's complement throughout; 25-bit internal width cannot overflow for legal 16-bit data.

Test Plan:
- Clean block: random cn, chk_s/chk_w computed exactly, in_valid 1 cycle → done_o in cycle 2, no_error=1, fix_en_o=0, error_code=15.
- cn3 sample 5 real corrupted by +100 → done_o in cycle 6, fix_en_o=1, error_code=3, delta1_real[5]=100, all other deltas 0.
- cn7 all samples imag corrupted by -1 → done_o in cycle 10, error_code=7, delta1_imag[*]=-1.
- cn0 and cn2 both corrupted by +1 at the same lane → d2=4, d1=2, match at k=1 (error_code=1, delta1=2), proving aliasing is reported as-is. Then a separate case with cn0 +1 and cn1 +2 (d1=3, d2=5, no integer match) → uncorrectable=1, done_o in cycle 10, fix_en_o=0.
- chk_s lane corrupted by +70000 → d1 overflow, uncorrectable=1, done_o in cycle 2; in_valid pulses during busy ignored.
- rst pulsed while in SEARCH at k=4 → all outputs to reset values immediately, no done_o; next block processes normally.
